// File: rtl/display_pkg.sv
// Shared types and hex glyph table for the multiplexed 7-segment display driver.
// Glyphs are stored active-high in {g,f,e,d,c,b,a} order; pin polarity is applied by the user.
package display_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;

  localparam seg7_t SEG_0 = 7'h3F;
  localparam seg7_t SEG_1 = 7'h06;
  localparam seg7_t SEG_2 = 7'h5B;
  localparam seg7_t SEG_3 = 7'h4F;
  localparam seg7_t SEG_4 = 7'h66;
  localparam seg7_t SEG_5 = 7'h6D;
  localparam seg7_t SEG_6 = 7'h7D;
  localparam seg7_t SEG_7 = 7'h07;
  localparam seg7_t SEG_8 = 7'h7F;
  localparam seg7_t SEG_9 = 7'h6F;
  localparam seg7_t SEG_A = 7'h77;
  localparam seg7_t SEG_B = 7'h7C;
  localparam seg7_t SEG_C = 7'h39;
  localparam seg7_t SEG_D = 7'h5E;
  localparam seg7_t SEG_E = 7'h79;
  localparam seg7_t SEG_F = 7'h71;

  function automatic seg7_t hex_to_seg(input logic [3:0] hex);
    case (hex)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex-to-7-segment decoder, active-high glyph output.
module hex7seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit hex 7-segment driver with shadow register, per-digit
// enables, decimal points, leading-zero blanking and a blank phase against ghosting.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS         = 4,
  parameter int REFRESH_DIV      = 100000,
  parameter int BLANK_CYCLES     = 2,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*N_DIGITS-1:0]         digits_in,
  input  logic [N_DIGITS-1:0]           dp_in,
  input  logic [N_DIGITS-1:0]           digit_en,
  input  logic                          lz_blank,
  input  logic                          load,
  output logic [N_DIGITS-1:0]           anodes,
  output logic [6:0]                    segments,
  output logic                          dp,
  output logic [$clog2(N_DIGITS)-1:0]   scan_idx,
  output logic                          frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(N_DIGITS - 1);
  localparam logic AN_INV  = (ANODE_ACTIVE_LOW != 0);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam phase_t PH_RESET = (BLANK_CYCLES > 0) ? PH_BLANK : PH_DRIVE;

  logic [PW-1:0]              prescaler_q, prescaler_d;
  logic [SW-1:0]              scan_idx_q, scan_idx_d;
  logic                       frame_done_q, frame_done_d;
  phase_t                     phase_q, phase_d;
  logic [N_DIGITS-1:0][3:0]   shadow_digits_q, shadow_digits_d;
  logic [N_DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
  logic [N_DIGITS-1:0]        anodes_q, anodes_d;
  logic [6:0]                 segments_q, segments_d;
  logic                       dp_q, dp_d;

  logic                       slot_end;
  logic                       blank_next;
  logic [N_DIGITS-1:0]        upper_zero;
  logic                       digit_lit;
  seg7_t                      glyph;

  assign slot_end = (prescaler_q == PRE_LAST);

  // The phase register tracks the prescaler, so it is decided from the prescaler's next value.
  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign blank_next = 1'b0;
    end else begin : g_blank
      localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);
      assign blank_next = (prescaler_d < BLANK_LIM);
    end
  endgenerate

  always_comb begin
    prescaler_d     = slot_end ? '0 : prescaler_q + 1'b1;
    scan_idx_d      = scan_idx_q;
    if (slot_end) begin
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end
    frame_done_d    = slot_end && (scan_idx_q == IDX_LAST);
    phase_d         = blank_next ? PH_BLANK : PH_DRIVE;
    shadow_digits_d = load ? digits_in : shadow_digits_q;
    shadow_dp_d     = load ? dp_in : shadow_dp_q;
  end

  hex7seg_decoder u_decoder (
    .hex (shadow_digits_q[scan_idx_q]),
    .seg (glyph)
  );

  // upper_zero[i] is set when shadow digits i..N_DIGITS-1 are all zero.
  always_comb begin
    logic acc;
    upper_zero = '0;
    acc        = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      acc           = acc && (shadow_digits_q[i] == 4'h0);
      upper_zero[i] = acc;
    end
  end

  always_comb begin
    logic [N_DIGITS-1:0] an_act;
    seg7_t               seg_act;
    logic                dp_act;
    an_act    = '0;
    seg_act   = '0;
    dp_act    = 1'b0;
    digit_lit = digit_en[scan_idx_q] &&
                !(lz_blank && (scan_idx_q != '0) && upper_zero[scan_idx_q]);
    if (phase_q == PH_DRIVE) begin
      an_act[scan_idx_q] = 1'b1;
      if (digit_lit) begin
        seg_act = glyph;
        dp_act  = shadow_dp_q[scan_idx_q];
      end
    end
    anodes_d   = an_act ^ {N_DIGITS{AN_INV}};
    segments_d = seg_act ^ {7{SEG_INV}};
    dp_d       = dp_act ^ SEG_INV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q     <= '0;
      scan_idx_q      <= '0;
      frame_done_q    <= 1'b0;
      phase_q         <= PH_RESET;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      anodes_q        <= {N_DIGITS{AN_INV}};
      segments_q      <= {7{SEG_INV}};
      dp_q            <= SEG_INV;
    end else begin
      prescaler_q     <= prescaler_d;
      scan_idx_q      <= scan_idx_d;
      frame_done_q    <= frame_done_d;
      phase_q         <= phase_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      anodes_q        <= anodes_d;
      segments_q      <= segments_d;
      dp_q            <= dp_d;
    end
  end

  assign anodes     = anodes_q;
  assign segments   = segments_q;
  assign dp         = dp_q;
  assign scan_idx   = scan_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: two instances (4-digit with blank phase,
// 3-digit without) checked cycle by cycle against a time-based reference model.
module tb_display_scan_ctrl;

  localparam int NA = 4, RA = 8, BA = 2;
  localparam int NB = 3, RB = 5, BB = 0;

  typedef struct packed {
    int           cyc;
    logic [63:0]  dig;
    logic [15:0]  dpv;
  } model_t;

  typedef struct packed {
    logic [15:0] an;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  idx;
    logic        fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;

  logic [NA-1:0] an_a;
  logic [6:0]    seg_a;
  logic          dp_a;
  logic [1:0]    idx_a;
  logic          fd_a;
  logic [NB-1:0] an_b;
  logic [6:0]    seg_b;
  logic          dp_b;
  logic [1:0]    idx_b;
  logic          fd_b;

  int     checks = 0;
  int     errors = 0;
  model_t ma = '0;
  model_t mb = '0;
  exp_t   qa[$];
  exp_t   qb[$];

  always #5 clk = ~clk;

  display_scan_ctrl #(.N_DIGITS(NA), .REFRESH_DIV(RA), .BLANK_CYCLES(BA),
                      .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
    .anodes(an_a), .segments(seg_a), .dp(dp_a), .scan_idx(idx_a), .frame_done(fd_a));

  display_scan_ctrl #(.N_DIGITS(NB), .REFRESH_DIV(RB), .BLANK_CYCLES(BB),
                      .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset(reset), .digits_in(digits_in[11:0]), .dp_in(dp_in[2:0]),
    .digit_en(digit_en[2:0]), .lz_blank(lz_blank), .load(load),
    .anodes(an_b), .segments(seg_b), .dp(dp_b), .scan_idx(idx_b), .frame_done(fd_b));

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[h];
  endfunction

  // Expected pins after the coming edge: slot = cycle/REFRESH_DIV, position = cycle%REFRESH_DIV.
  function automatic exp_t predict(input int n, input int r, input int b, input model_t m,
                                   input logic rst, input logic [3:0] en, input logic lzb);
    exp_t e;
    int   pos, idx;
    logic allz, lit;
    e = '{an: 16'hFFFF, seg: 7'h7F, dp: 1'b1, idx: 4'd0, fd: 1'b0};
    if (!rst) begin
      pos = m.cyc % r;
      idx = (m.cyc / r) % n;
      if (pos >= b) begin
        allz = 1'b1;
        for (int j = idx; j < n; j++) if (m.dig[4*j +: 4] != 4'h0) allz = 1'b0;
        lit  = en[idx] && !(lzb && idx != 0 && allz);
        e.an = ~(16'd1 << idx);
        if (lit) begin
          e.seg = ~glyph(m.dig[4*idx +: 4]);
          e.dp  = ~m.dpv[idx];
        end
      end
      e.idx = 4'(((m.cyc + 1) / r) % n);
      e.fd  = ((m.cyc + 1) % (r * n)) == 0;
    end
    return e;
  endfunction

  function automatic model_t advance(input model_t m, input logic rst, input logic ld,
                                     input logic [15:0] d, input logic [3:0] p);
    model_t nm = m;
    if (rst) begin
      nm = '0;
    end else begin
      nm.cyc = m.cyc + 1;
      if (ld) begin
        nm.dig = {48'h0, d};
        nm.dpv = {12'h0, p};
      end
    end
    return nm;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [15:0] d, input logic [3:0] p,
                               input logic [3:0] en, input logic lzb, input logic ld);
    @(negedge clk);
    reset = rst; digits_in = d; dp_in = p; digit_en = en; lz_blank = lzb; load = ld;
    qa.push_back(predict(NA, RA, BA, ma, rst, en, lzb));
    qb.push_back(predict(NB, RB, BB, mb, rst, {1'b0, en[2:0]}, lzb));
    ma = advance(ma, rst, ld, d, p);
    mb = advance(mb, rst, ld, {4'h0, d[11:0]}, {1'b0, p[2:0]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, digits_in, dp_in, digit_en, lz_blank, 1'b0);
  endtask

  // Monitor: every edge the DUTs present a new pin state; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        checkOutput("A.anodes",     16'(an_a),  e.an & 16'h000F);
        checkOutput("A.segments",   16'(seg_a), 16'(e.seg));
        checkOutput("A.dp",         16'(dp_a),  16'(e.dp));
        checkOutput("A.scan_idx",   16'(idx_a), 16'(e.idx));
        checkOutput("A.frame_done", 16'(fd_a),  16'(e.fd));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        checkOutput("B.anodes",     16'(an_b),  e.an & 16'h0007);
        checkOutput("B.segments",   16'(seg_b), 16'(e.seg));
        checkOutput("B.dp",         16'(dp_b),  16'(e.dp));
        checkOutput("B.scan_idx",   16'(idx_b), 16'(e.idx));
        checkOutput("B.frame_done", 16'(fd_b),  16'(e.fd));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] d;
    applyStimulus(1'b1, 16'h0000, 4'h0, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0000, 4'h0, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h1A30, 4'h0, 4'hF, 1'b0, 1'b1);
    idle(70);

    applyStimulus(1'b0, 16'h0005, 4'h0, 4'hF, 1'b1, 1'b1);
    idle(34);
    applyStimulus(1'b0, 16'h0000, 4'h0, 4'hF, 1'b1, 1'b1);
    idle(34);

    applyStimulus(1'b0, 16'h1A30, 4'h0, 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 16'(i * 16'h1111), 4'h0, 4'hF, 1'b0, 1'b0);
    while (ma.cyc % RA != RA - 1) idle(1);
    applyStimulus(1'b0, 16'hBEEF, 4'h0, 4'hF, 1'b0, 1'b1);
    idle(34);

    applyStimulus(1'b0, 16'h1234, 4'b0100, 4'b1011, 1'b0, 1'b1);
    idle(34);

    while (ma.cyc % (RA * NA) != 2 * RA + 4) idle(1);
    applyStimulus(1'b1, digits_in, dp_in, 4'hF, 1'b0, 1'b0);
    idle(20);

    for (int i = 0; i < 600; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d = d & (16'hFFFF >> (4 * $urandom_range(1, 4)));
      applyStimulus(($urandom_range(0, 199) == 0), d, 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0));
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("A.queue_drained", 16'(qa.size()), 16'd0);
    checkOutput("B.queue_drained", 16'(qb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
